// File: rtl/dynode_pkg.sv
// Shared definitions for the dynode trigger path.
// Used by the baseline estimator and by the event detector arithmetic.
package dynode_pkg;

    localparam int ADCW = 12;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_ACC  = 1'b1
    } bl_state_t;

    // Saturate a signed (ADCW+1)-bit difference of two unsigned samples to [0, 2^ADCW-1].
    function automatic logic [ADCW-1:0] clamp_u(input logic signed [ADCW:0] d);
        return d[ADCW] ? '0 : d[ADCW-1:0];
    endfunction

endpackage

// File: rtl/dynode_dlyline.sv
// Fixed-depth shift register with synchronous clear.
// Aligns the accumulator sample with the event detector's indet decision.
module dynode_dlyline #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // NOTE: non-blocking assignments let every stage capture its neighbour's pre-edge value.
    // NOTE: this storage is cleared on reset so pre-reset samples never reach the accumulator.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/dynode_baseline.sv
// Dynode baseline estimator: block-averages quiet ADC samples and outputs the
// baseline-corrected stream, with tracking gated by the event detector's indet flag.
module dynode_baseline #(
    parameter int ADCW     = dynode_pkg::ADCW,
    parameter int AVGSHIFT = 6,
    parameter int HOLDOFF  = 16,
    parameter int SMPDLY   = 8,
    parameter int POLARITY = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ADCW-1:0] adc_in,
    input  logic            dyn_indet,
    input  logic            bl_freeze,
    output logic [ADCW-1:0] dyn_blcor,
    output logic [ADCW-1:0] baseline,
    output logic            bl_valid,
    output logic            bl_upd
);

    import dynode_pkg::*;

    localparam int ACCW = ADCW + AVGSHIFT;
    localparam int HOW  = $clog2(HOLDOFF + 1);
    localparam logic [HOW-1:0]      HO_LOAD  = HOW'(HOLDOFF);
    localparam logic [AVGSHIFT-1:0] CNT_LAST = '1;

    logic [ADCW-1:0]        w_adc_pol;
    logic [ADCW-1:0]        w_smp_d;
    logic signed [ADCW:0]   w_diff;
    logic [ACCW-1:0]        w_acc_sum;
    logic                   w_quiet;

    logic [ADCW-1:0]        r_adc;
    logic [ADCW-1:0]        r_blcor;
    logic [ADCW-1:0]        r_baseline;
    logic                   r_bl_valid;
    logic                   r_bl_upd;
    logic [ACCW-1:0]        r_acc;
    logic [AVGSHIFT-1:0]    r_cnt;
    logic [HOW-1:0]         r_hocnt;
    bl_state_t              r_state;

    // Inversion equals (2^ADCW-1) - adc_in, making negative-going pulses positive.
    assign w_adc_pol = (POLARITY != 0) ? ~adc_in : adc_in;
    assign w_diff    = $signed({1'b0, r_adc}) - $signed({1'b0, r_baseline});
    assign w_acc_sum = r_acc + ACCW'(w_smp_d);
    assign w_quiet   = !(dyn_indet || bl_freeze);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adc   <= '0;
            r_blcor <= '0;
        end else begin
            r_adc   <= w_adc_pol;
            r_blcor <= r_bl_valid ? clamp_u(w_diff) : '0;
        end
    end

    dynode_dlyline #(
        .WIDTH (ADCW),
        .DEPTH (SMPDLY)
    ) u_dly (
        .clk   (clk),
        .i_clr (reset),
        .i_d   (r_adc),
        .o_q   (w_smp_d)
    );

    // Any indet/freeze discards the open window; the baseline only moves on a full quiet window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_HOLD;
            r_hocnt    <= HO_LOAD;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_baseline <= '0;
            r_bl_valid <= 1'b0;
            r_bl_upd   <= 1'b0;
        end else begin
            r_bl_upd <= 1'b0;
            case (r_state)
                S_HOLD: begin
                    if (!w_quiet) begin
                        r_hocnt <= HO_LOAD;
                    end else if (r_hocnt == HOW'(1)) begin
                        r_state <= S_ACC;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_hocnt <= r_hocnt - HOW'(1);
                    end
                end
                S_ACC: begin
                    if (!w_quiet) begin
                        r_state <= S_HOLD;
                        r_hocnt <= HO_LOAD;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_baseline <= ADCW'(w_acc_sum >> AVGSHIFT);
                        r_bl_valid <= 1'b1;
                        r_bl_upd   <= 1'b1;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                    end else begin
                        r_acc <= w_acc_sum;
                        r_cnt <= r_cnt + AVGSHIFT'(1);
                    end
                end
                default: begin
                    r_state <= S_HOLD;
                    r_hocnt <= HO_LOAD;
                end
            endcase
        end
    end

    assign dyn_blcor = r_blcor;
    assign baseline  = r_baseline;
    assign bl_valid  = r_bl_valid;
    assign bl_upd    = r_bl_upd;

endmodule

// File: tb/tb_dynode_baseline.sv
// Scoreboard bench for dynode_baseline: both polarities run side by side against
// a reference model built on quiet-run length and a raw sample history.
`timescale 1ns/1ps
module tb_dynode_baseline;

    localparam int ADCW     = 12;
    localparam int AVGSHIFT = 6;
    localparam int HOLDOFF  = 16;
    localparam int SMPDLY   = 8;
    localparam int WIN      = 1 << AVGSHIFT;
    localparam int MAXV     = (1 << ADCW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [ADCW-1:0] adc_in = '0;
    logic            dyn_indet = 1'b0;
    logic            bl_freeze = 1'b0;
    logic [ADCW-1:0] blcor [2];
    logic [ADCW-1:0] base  [2];
    logic            valid [2];
    logic            upd   [2];

    always #5 clk = ~clk;

    dynode_baseline #(.POLARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .adc_in(adc_in), .dyn_indet(dyn_indet),
        .bl_freeze(bl_freeze), .dyn_blcor(blcor[0]), .baseline(base[0]),
        .bl_valid(valid[0]), .bl_upd(upd[0])
    );

    dynode_baseline #(.POLARITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .adc_in(adc_in), .dyn_indet(dyn_indet),
        .bl_freeze(bl_freeze), .dyn_blcor(blcor[1]), .baseline(base[1]),
        .bl_valid(valid[1]), .bl_upd(upd[1])
    );

    typedef struct packed {
        logic                 rst;
        logic [1:0][ADCW-1:0] blcor;
        logic [1:0][ADCW-1:0] base;
        logic [1:0]           valid;
        logic [1:0]           upd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state: raw input history (-1 marks a reset-cleared slot) and quiet-run length.
    int m_hist[$];
    int m_quiet;
    int m_base [2];
    bit m_valid[2];

    // Directed timing observations of the POLARITY=0 instance.
    int edge_cnt  = 0;
    int first_upd = -1;
    int last_upd  = -1;
    int upd_gap   = -1;

    task automatic check(input string name, input int idx, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t got 0x%0h expected 0x%0h", name, idx, $time, act, expv);
        end
    endtask

    function automatic int corr(input int v, input int p);
        if (v < 0) return 0;
        return (p != 0) ? (MAXV - v) : v;
    endfunction

    // A window completes when a quiet run has covered the holdoff plus a whole number of windows;
    // it averages the samples that entered SMPDLY+1 cycles before each accumulation cycle.
    task automatic model_edge(input int adc, input bit indet, input bit frz, input bit rst,
                              output exp_t e);
        int a_prev;
        int sum;
        e = '0;
        e.rst = rst;
        if (rst) begin
            m_quiet = 0;
            m_hist.delete();
            repeat (SMPDLY + 1) m_hist.push_back(-1);
            for (int p = 0; p < 2; p++) begin
                m_base[p]  = 0;
                m_valid[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                a_prev = corr(m_hist[m_hist.size()-1], p);
                if (m_valid[p] && a_prev > m_base[p])
                    e.blcor[p] = ADCW'(a_prev - m_base[p]);
            end
            if (!indet && !frz) m_quiet++;
            else m_quiet = 0;
            if (m_quiet >= HOLDOFF + WIN && ((m_quiet - HOLDOFF) % WIN) == 0) begin
                for (int p = 0; p < 2; p++) begin
                    sum = 0;
                    for (int i = 0; i < WIN; i++)
                        sum += corr(m_hist[m_hist.size()-1-SMPDLY-i], p);
                    m_base[p]  = sum / WIN;
                    m_valid[p] = 1'b1;
                    e.upd[p]   = 1'b1;
                end
            end
            m_hist.push_back(adc);
            if (m_hist.size() > 256) void'(m_hist.pop_front());
            for (int p = 0; p < 2; p++) begin
                e.base[p]  = ADCW'(m_base[p]);
                e.valid[p] = m_valid[p];
            end
        end
    endtask

    task automatic step(input logic [ADCW-1:0] adc, input bit indet, input bit frz, input bit rst);
        exp_t e;
        @(negedge clk);
        adc_in    = adc;
        dyn_indet = indet;
        bl_freeze = frz;
        reset     = rst;
        model_edge(int'(adc), indet, frz, rst, e);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [ADCW-1:0] adc, input bit indet, input bit frz);
        for (int i = 0; i < n; i++) step(adc, indet, frz, 1'b0);
    endtask

    task automatic sample();
        @(posedge clk);
        #3;
    endtask

    // Monitor: pops one expectation per clock edge and compares every output of both instances.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < 2; p++) begin
                    check("dyn_blcor", p, int'(blcor[p]), int'(e.blcor[p]));
                    check("baseline",  p, int'(base[p]),  int'(e.base[p]));
                    check("bl_valid",  p, int'(valid[p]), int'(e.valid[p]));
                    check("bl_upd",    p, int'(upd[p]),   int'(e.upd[p]));
                end
                if (e.rst) begin
                    edge_cnt  = 0;
                    first_upd = -1;
                    last_upd  = -1;
                    upd_gap   = -1;
                end else begin
                    edge_cnt++;
                    if (upd[0]) begin
                        if (first_upd < 0) first_upd = edge_cnt;
                        else if (upd_gap < 0) upd_gap = edge_cnt - last_upd;
                        last_upd = edge_cnt;
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog t=%0t got timeout expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lvl;
        int burst;
        int frz;
        int v;

        // Constant input: first update 80 edges after reset, then every 64.
        repeat (3) step(12'h200, 1'b0, 1'b0, 1'b1);
        run(HOLDOFF + 3 * WIN, 12'h200, 1'b0, 1'b0);
        sample();
        check("first_upd_edge", 0, first_upd, 80);
        check("upd_gap", 0, upd_gap, 64);
        check("const_baseline", 0, int'(base[0]), 'h200);
        check("const_valid", 0, int'(valid[0]), 1);
        check("const_blcor", 0, int'(blcor[0]), 0);

        // Alternating input averages to the midpoint; correction alternates.
        repeat (2) step(12'h200, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 84; i++) step((i % 2) ? 12'h210 : 12'h1F0, 1'b0, 1'b0, 1'b0);
        step(12'h1F0, 1'b0, 1'b0, 1'b0);
        sample();
        check("alt_baseline", 0, int'(base[0]), 'h200);
        check("alt_blcor_hi", 0, int'(blcor[0]), 'h010);
        step(12'h210, 1'b0, 1'b0, 1'b0);
        sample();
        check("alt_blcor_lo", 0, int'(blcor[0]), 'h000);

        // Pulse with indet from its third cycle: correction visible, baseline untouched.
        step(12'h200, 1'b1, 1'b0, 1'b0);
        run(90, 12'h200, 1'b0, 1'b0);
        step(12'h600, 1'b0, 1'b0, 1'b0);
        step(12'h600, 1'b0, 1'b0, 1'b0);
        sample();
        check("pulse_blcor", 0, int'(blcor[0]), 'h400);
        for (int i = 2; i < 22; i++) step((i < 10) ? 12'h600 : 12'h200, 1'b1, 1'b0, 1'b0);
        run(HOLDOFF + WIN + 4, 12'h200, 1'b0, 1'b0);
        sample();
        check("pulse_baseline", 0, int'(base[0]), 'h200);

        // indet on the last sample of a window discards it; a fresh holdoff follows.
        step(12'h280, 1'b1, 1'b0, 1'b0);
        run(HOLDOFF + WIN - 1, 12'h280, 1'b0, 1'b0);
        step(12'h280, 1'b1, 1'b0, 1'b0);
        sample();
        check("lastsmp_baseline", 0, int'(base[0]), 'h200);
        check("lastsmp_upd", 0, int'(upd[0]), 0);
        run(HOLDOFF + WIN, 12'h280, 1'b0, 1'b0);
        sample();
        check("after_hold_baseline", 0, int'(base[0]), 'h280);

        // Inverted polarity and clamp of a below-baseline sample.
        repeat (2) step(12'h200, 1'b0, 1'b0, 1'b1);
        run(HOLDOFF + WIN + 4, 12'hDFF, 1'b0, 1'b0);
        sample();
        check("pol_baseline", 1, int'(base[1]), 'h200);
        check("pol_valid", 1, int'(valid[1]), 1);
        run(2, 12'hE0F, 1'b0, 1'b0);
        sample();
        check("pol_clamp", 1, int'(blcor[1]), 0);

        // Freeze mid-window, step the input, release, then reset.
        repeat (2) step(12'h200, 1'b0, 1'b0, 1'b1);
        run(100, 12'h200, 1'b0, 1'b0);
        run(200, 12'h300, 1'b0, 1'b1);
        sample();
        check("freeze_baseline", 0, int'(base[0]), 'h200);
        run(HOLDOFF + WIN - 1, 12'h300, 1'b0, 1'b0);
        sample();
        check("release_79", 0, int'(base[0]), 'h200);
        step(12'h300, 1'b0, 1'b0, 1'b0);
        sample();
        check("release_80", 0, int'(base[0]), 'h300);
        step(12'h300, 1'b0, 1'b0, 1'b1);
        sample();
        check("reset_valid", 0, int'(valid[0]), 0);
        check("reset_blcor", 0, int'(blcor[0]), 0);

        // Randomised traffic: noisy levels, pulses with indet, freezes, rare resets.
        step(12'h300, 1'b0, 1'b0, 1'b1);
        lvl   = 'h200;
        burst = 0;
        frz   = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) lvl = int'($urandom_range(16'h100, 16'h700));
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = int'($urandom_range(3, 25));
            if (frz == 0 && $urandom_range(0, 399) == 0) frz = int'($urandom_range(5, 40));
            v = lvl + int'($urandom_range(0, 15)) - 8;
            if (burst > 0) v += 'h300;
            step(ADCW'(v), burst > 0, frz > 0, $urandom_range(0, 999) == 0);
            if (burst > 0) burst--;
            if (frz > 0) frz--;
        end
        step(12'h200, 1'b0, 1'b0, 1'b0);
        sample();
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
